elastic_pipe_reg: RTL

- Parametrised successor to the fixed-width enable/clear registers: a chain of DEPTH elastic register stages, each WIDTH bits, with per-stage valid bits.
- Uses a valid/ready handshake with bubble collapsing, a synchronous flush, and an occupancy count.
- Serves as the standard inter-stage latch for the pipelined processor (F/D, D/X, X/M, M/W) and for multicycle-unit operand buffering. It replaces hand-built stall/flush logic around plain registers.

---
 rtl/elastic_pipe_reg.sv | 88 ++++++++
 1 files changed

// File: rtl/elastic_pipe_reg.sv
// Chain of DEPTH elastic register stages with a valid/ready handshake. Empty stages
// accept even when downstream stalls. Also provides a synchronous flush and an occupancy count.
module elastic_pipe_reg #(
    parameter int               WIDTH             = 32,
    parameter int               DEPTH             = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE       = '0,
    parameter bit               FLUSH_CLEARS_DATA = 1'b0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] r_vld;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [CW-1:0]    r_count;

    logic [DEPTH-1:0] w_rdy;
    logic [DEPTH-1:0] w_prev_vld;
    logic [WIDTH-1:0] w_prev_data [DEPTH];
    logic             w_in_xfer;
    logic             w_out_xfer;

    // A stage is ready if downstream accepts or any stage from here to the output is empty;
    // this is the unrolled form of rdy[i] = !v[i] | rdy[i+1].
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        assign w_rdy[g] = out_ready | ~(&r_vld[DEPTH-1:g]);
        if (g == 0) begin : g_head
            assign w_prev_vld[g]  = in_valid;
            assign w_prev_data[g] = in_data;
        end else begin : g_body
            assign w_prev_vld[g]  = r_vld[g-1];
            assign w_prev_data[g] = r_data[g-1];
        end
    end

    assign in_ready   = w_rdy[0] & ~flush;
    assign out_valid  = r_vld[DEPTH-1];
    assign out_data   = r_data[DEPTH-1];
    assign count      = r_count;
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = r_vld[DEPTH-1] & out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RESET_VALUE;
            end
        end else if (flush) begin
            r_vld <= '0;
            if (FLUSH_CLEARS_DATA) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_data[i] <= RESET_VALUE;
                end
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_rdy[i]) begin
                    r_vld[i] <= w_prev_vld[i];
                    if (w_prev_vld[i]) begin
                        r_data[i] <= w_prev_data[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(w_in_xfer) - CW'(w_out_xfer);
        end
    end

endmodule
